spw_ser_tx: RTL and testbench

Parallel-to-serial transmitter for the SpaceWire router's SelectIO path: the transmit-side counterpart of the `ISERDESE2` deserializer. It accepts DATA_WIDTH-bit words over a valid/ready handshake, buffers one word, and shifts one bit per CLK onto a single-bit output. Back-to-back words stream with no idle gap. Bit order is chosen so that a `ISERDESE2` sampling Q on the same clock holds Q(k) = DIN[k-1] once a whole word has arrived.

---
 rtl/spw_ser_tx.sv | 134 +++++++++++++
 tb/tb_spw_ser_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spw_ser_tx.sv
// spw_ser_tx: parallel-to-serial transmitter for the SelectIO transmit path, MSB first.
// Latency: a word accepted while idle drives its first bit on Q after the accepting edge.
// Backpressure: one-word holding register; DIN_READY low while it is occupied.
//
// Ports:
//   CLK, RST_N      clock, asynchronous active-low reset
//   DIN/DIN_VALID   parallel word in; accepted when DIN_VALID && DIN_READY
//   DIN_READY       holding register empty (combinational from registers and RST_N)
//   Q               registered serial data, IDLE_LEVEL when nothing is shifting
//   BUSY            a word is being shifted onto Q
//   WORD_DONE       pulse while the last bit of a word is on Q
//   GAP             pulse on the first idle cycle after a word (underrun)
module spw_ser_tx #(
  parameter int   DATA_WIDTH = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  DIN_VALID,
  output logic                  DIN_READY,
  output logic                  Q,
  output logic                  BUSY,
  output logic                  WORD_DONE,
  output logic                  GAP
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } st_t;

  st_t                   r_st;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_sr;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hv;
  logic                  r_q;
  logic                  r_word_done;
  logic                  r_gap;

  st_t                   w_st_nxt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_sr_nxt;
  logic [DATA_WIDTH-1:0] w_hold_nxt;
  logic                  w_hv_nxt;
  logic                  w_q_nxt;
  logic                  w_word_done_nxt;
  logic                  w_gap_nxt;

  logic                  w_accept;
  logic                  w_load_evt;
  logic [DATA_WIDTH-1:0] w_load_src;
  logic [CW-1:0]         w_cnt_inc;

  assign DIN_READY  = !r_hv && RST_N;
  assign w_accept   = DIN_VALID && DIN_READY;
  // The shifter can take a new word when idle or while its last bit is on Q;
  // loading on the last-bit edge is what makes back-to-back words gapless.
  assign w_load_evt = (r_st == ST_IDLE) || (r_cnt == CNT_LAST);
  // A held word always has priority; DIN can only be accepted when HOLD is empty.
  assign w_load_src = r_hv ? r_hold : DIN;
  assign w_cnt_inc  = r_cnt + CW'(1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_st        <= ST_IDLE;
      r_cnt       <= '0;
      r_sr        <= '0;
      r_hold      <= '0;
      r_hv        <= 1'b0;
      r_q         <= IDLE_LEVEL;
      r_word_done <= 1'b0;
      r_gap       <= 1'b0;
    end else begin
      r_st        <= w_st_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sr        <= w_sr_nxt;
      r_hold      <= w_hold_nxt;
      r_hv        <= w_hv_nxt;
      r_q         <= w_q_nxt;
      r_word_done <= w_word_done_nxt;
      r_gap       <= w_gap_nxt;
    end
  end

  always_comb begin
    w_st_nxt        = r_st;
    w_cnt_nxt       = r_cnt;
    w_sr_nxt        = r_sr;
    w_hold_nxt      = r_hold;
    w_hv_nxt        = r_hv;
    w_q_nxt         = r_q;
    w_word_done_nxt = 1'b0;
    w_gap_nxt       = 1'b0;

    if (w_load_evt) begin
      if (r_hv || w_accept) begin
        w_sr_nxt  = w_load_src;
        w_q_nxt   = w_load_src[DATA_WIDTH-1];
        w_cnt_nxt = '0;
        w_st_nxt  = ST_SHIFT;
        w_hv_nxt  = 1'b0;
      end else begin
        // Nothing to send: fall back to the idle level and flag an underrun
        // only if a word was actually being shifted.
        w_st_nxt  = ST_IDLE;
        w_q_nxt   = IDLE_LEVEL;
        w_cnt_nxt = '0;
        w_gap_nxt = (r_st == ST_SHIFT);
      end
    end else begin
      // Rotate rather than shift so the register stays fully used; the bit
      // after the current one is always at DATA_WIDTH-2 of the rotated word.
      w_sr_nxt        = {r_sr[DATA_WIDTH-2:0], r_sr[DATA_WIDTH-1]};
      w_q_nxt         = r_sr[DATA_WIDTH-2];
      w_cnt_nxt       = w_cnt_inc;
      w_word_done_nxt = (w_cnt_inc == CNT_LAST);
      if (w_accept) begin
        w_hold_nxt = DIN;
        w_hv_nxt   = 1'b1;
      end
    end
  end

  assign Q         = r_q;
  assign BUSY      = (r_st == ST_SHIFT);
  assign WORD_DONE = r_word_done;
  assign GAP       = r_gap;

endmodule

// File: tb/tb_spw_ser_tx.sv
// tb_spw_ser_tx: scoreboard bench for spw_ser_tx (8-bit/idle-0 and 2-bit/idle-1 instances).
// Stimulus pushes the expected serial bit stream per accepted word; monitors pop on each cycle.
// Bit stream, readiness, idle level and pulses are derived from word-level rules.
module tb_spw_ser_tx;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b1;
  logic [DW-1:0] DIN = '0;
  logic          DIN_VALID = 1'b0;
  logic          DIN_READY, Q, BUSY, WORD_DONE, GAP;

  logic [1:0]    DIN2 = '0;
  logic          DIN_VALID2 = 1'b0;
  logic          DIN_READY2, Q2, BUSY2, WORD_DONE2, GAP2;

  spw_ser_tx #(.DATA_WIDTH(DW), .IDLE_LEVEL(1'b0)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY),
    .Q(Q), .BUSY(BUSY), .WORD_DONE(WORD_DONE), .GAP(GAP)
  );

  spw_ser_tx #(.DATA_WIDTH(2), .IDLE_LEVEL(1'b1)) u_dut2 (
    .CLK(CLK), .RST_N(RST_N), .DIN(DIN2), .DIN_VALID(DIN_VALID2), .DIN_READY(DIN_READY2),
    .Q(Q2), .BUSY(BUSY2), .WORD_DONE(WORD_DONE2), .GAP(GAP2)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic b;
    logic last;
  } sb_t;

  sb_t           sb[$];      // expected serial bits, in line order
  logic [DW-1:0] wq[$];      // expected words, for the deserializer check
  logic [3:0]    q2[$];      // expected {Q,BUSY,WORD_DONE,GAP} for the 2-bit instance
  int            n_words = 0;
  int            total = 0;
  int            bad = 0;
  int            gap_cnt = 0;
  logic          prev_busy = 1'b0;
  logic          acc = 1'b0;
  logic [DW-1:0] cap = '0;
  logic [DW-1:0] last_cap = '0;
  sb_t           e;
  logic [DW-1:0] w_exp;
  logic [3:0]    e2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // MSB first: the i-th bit on the line is word[DW-1-i].
  task automatic push_word(input logic [DW-1:0] w);
    for (int i = 0; i < DW; i++) begin
      sb_t s;
      s.b    = w[DW-1-i];
      s.last = (i == DW - 1);
      sb.push_back(s);
    end
    wq.push_back(w);
    n_words++;
  endtask

  // Called at a negedge with inputs set; samples the handshake just before the
  // next posedge and returns at the following negedge.
  task automatic tick();
    #4;
    acc = RST_N && DIN_VALID && DIN_READY;
    if (acc) push_word(DIN);
    @(negedge CLK);
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [DW-1:0] w);
    logic [7:0] junk;
    DIN       = w;
    DIN_VALID = 1'b1;
    acc       = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) tick();
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    junk      = 8'($urandom_range(0, 255));
    DIN       = junk;
    DIN_VALID = 1'b0;
  endtask

  // Asserts reset two time units after a posedge, checks the asynchronous
  // response, drops the model contents, then releases between edges.
  task automatic do_reset(input int hold_cycles);
    #7;
    RST_N = 1'b0;
    #1;
    chk("rst_q", Q, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_ready", DIN_READY, 0);
    chk("rst_wd", WORD_DONE, 0);
    chk("rst_gap", GAP, 0);
    sb.delete();
    wq.delete();
    n_words   = 0;
    prev_busy = 1'b0;
    @(negedge CLK);
    repeat (hold_cycles) @(negedge CLK);
    #2;
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  // Monitor for the 8-bit instance: the line must be busy exactly while
  // accepted bits remain, and every busy cycle presents the next expected bit.
  always @(negedge CLK) begin
    chk("busy", BUSY, (sb.size() != 0));
    chk("ready", DIN_READY, RST_N && (n_words < 2));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("q_bit", Q, e.b);
      chk("word_done", WORD_DONE, e.last);
      chk("gap_busy", GAP, 0);
      cap = {cap[DW-2:0], Q};
      if (e.last) begin
        n_words--;
        w_exp    = wq.pop_front();
        last_cap = cap;
        chk("deser_word", cap, w_exp);
      end
      prev_busy = 1'b1;
    end else begin
      chk("q_idle", Q, 0);
      chk("wd_idle", WORD_DONE, 0);
      chk("gap_idle", GAP, prev_busy);
      if (GAP) gap_cnt++;
      prev_busy = 1'b0;
    end
  end

  // Monitor for the 2-bit instance: expected tuples when queued, idle otherwise.
  always @(negedge CLK) begin
    if (q2.size() != 0) begin
      e2 = q2.pop_front();
      chk("dw2_seq", {Q2, BUSY2, WORD_DONE2, GAP2}, e2);
    end else begin
      chk("dw2_idle", {Q2, BUSY2, WORD_DONE2, GAP2}, 4'b1000);
    end
  end

  int g0;

  initial begin
    #1;
    RST_N = 1'b0;
    #1;
    chk("init_q", Q, 0);
    chk("init_busy", BUSY, 0);
    chk("init_ready", DIN_READY, 0);
    repeat (3) @(negedge CLK);
    #2;
    RST_N = 1'b1;
    @(negedge CLK);

    // Idle after reset: no pulses, ready high.
    idle_ticks(20);
    chk("idle_ready", DIN_READY, 1);
    chk("idle_gaps", gap_cnt, 0);

    // Single word, then loopback word through the bench deserializer.
    send(8'hA5);
    idle_ticks(12);
    chk("a5_deser", last_cap, 8'hA5);
    chk("a5_gap_count", gap_cnt, 1);
    send(8'h3C);
    idle_ticks(12);
    chk("loopback_3c", last_cap, 8'h3C);

    // Streaming with valid held high across words.
    g0 = gap_cnt;
    send(8'hFF);
    send(8'h00);
    send(8'h81);
    idle_ticks(30);
    chk("stream_one_gap", gap_cnt, g0 + 1);
    chk("stream_last", last_cap, 8'h81);

    // Late word: offered while the previous last bit is on Q, with HOLD empty.
    g0 = gap_cnt;
    send(8'h96);
    idle_ticks(7);
    chk("late_wd", WORD_DONE, 1);
    chk("late_ready", DIN_READY, 1);
    send(8'h69);
    idle_ticks(12);
    chk("late_no_gap", gap_cnt, g0 + 1);

    // Reset mid-word with a second word held.
    send(8'hF0);
    tick();
    send(8'h0F);
    chk("hold_full", DIN_READY, 0);
    do_reset(2);
    send(8'h5A);
    idle_ticks(12);
    chk("after_reset_word", last_cap, 8'h5A);

    // 2-bit / idle-high instance: 2'b10 then 2'b01 back to back.
    DIN2 = 2'b10;
    DIN_VALID2 = 1'b1;
    #4;
    chk("dw2_ready0", DIN_READY2, 1);
    q2.push_back(4'b1100);
    q2.push_back(4'b0110);
    q2.push_back(4'b0100);
    q2.push_back(4'b1110);
    q2.push_back(4'b1001);
    @(negedge CLK);
    DIN2 = 2'b01;
    #4;
    chk("dw2_ready1", DIN_READY2, 1);
    @(negedge CLK);
    DIN_VALID2 = 1'b0;
    DIN2 = 2'b00;
    repeat (6) @(negedge CLK);

    // Randomized traffic: mix of streaming and gaps of assorted lengths.
    for (int n = 0; n < 60; n++) begin
      send(DW'($urandom_range(0, 255)));
      if ($urandom_range(0, 2) == 0) idle_ticks($urandom_range(0, 12));
    end
    idle_ticks(15);
    chk("drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
